debounce_scheduler: RTL
=======================

Name: debounce_scheduler

Overview:
Shared-resource debounce controller for N push-button inputs. Instead of one settle counter per button, a single settle counter is time-multiplexed round-robin across all channels by a small FSM. The block produces a debounced level per channel, one-cycle press/release pulses, and an event record with a valid/ready handshake. It sits between the board button pins and the CPU I/O / clock-control logic.

Parameters:
N_BTN, 4, number of button channels (>=1)
SETTLE_CYCLES, 524288, cycles an input must stay stable before commit (>=2; benches override to 8)
IDX_W, max(1,clog2(N_BTN)), channel index width (derived)

Ports:
iClock  in  1  system clock, rising edge
iReset_n  in  1  asynchronous, active-low reset
iButtons  in  N_BTN  raw bouncy inputs, asynchronous to iClock
iEventReady  in  1  consumer accepts event
oState  out  N_BTN  debounced level per channel
oPressPulse  out  N_BTN  one-cycle pulse on committed 0->1
oReleasePulse  out  N_BTN  one-cycle pulse on committed 1->0
oEventValid  out  1  event record valid
oEventCode  out  IDX_W+1  {edge (1=press, 0=release), channel index}
oBusy  out  1  FSM not in SCAN
oChannel  out  IDX_W  current scan pointer P

Behaviour:
- Reset (async assert, sync release): all outputs 0, sync flops 0, FSM=SCAN, P=0, counter=0. Reset mid-SETTLE/REPORT discards work; no pulse or event is emitted.
- Sync: 2-FF synchronizer per channel; S[i] = second stage. Raw-to-S latency is 2 cycles.
- SCAN: if S[P] != oState[P]: Target<=S[P], counter<=0, go SETTLE. Else P<=(P==N_BTN-1)?0:P+1. One channel examined per cycle. For N_BTN=1, P stays 0.
- SETTLE: if S[P] != Target: abort to SCAN, P advances, oState unchanged. Else if counter==SETTLE_CYCLES-1: go COMMIT. Else counter++. Counter width is clog2(SETTLE_CYCLES); no wrap is possible.
- COMMIT (1 cycle): oState[P]<=Target; oPressPulse[P]<=Target, oReleasePulse[P]<=!Target (registered, high only the next cycle); oEventCode<={Target,P}; oEventValid<=1; go REPORT.
- REPORT: hold oEventValid/oEventCode stable. Transfer occurs when oEventValid&&iEventReady: oEventValid<=0, P advances, go SCAN. Scanning is stalled during REPORT; other channels' changes are picked up afterwards (levels, not lost edges).
- Pulses coincide with the first REPORT cycle. At most one channel pulses per cycle.
- Latency for a clean edge with iEventReady=1: 2 (sync) + 0..N_BTN-1 (scan) + 1 (SCAN decision) + SETTLE_CYCLES + 1 (COMMIT) cycles to pulse.
- oBusy=1 in SETTLE/COMMIT/REPORT. oChannel=P.
- A glitch shorter than SETTLE_CYCLES never changes oState.

Decomposition:
- Package debounce_pkg: FSM state encoding (SCAN, SETTLE, COMMIT, REPORT), event code field positions (EDGE_BIT, index LSB), clog2 helper, edge constants PRESS=1/RELEASE=0.
- Sub-module input_sync: parameterised N-bit 2-FF synchronizer with async active-low reset. The scheduler FSM, counter and event register live in the top module.

Test Plan (N_BTN=4, SETTLE_CYCLES=8):
1. Assert iReset_n=0 with iButtons=4'hF -> all outputs 0 immediately. Release reset with iButtons=0 -> outputs stay 0 and oBusy=0 indefinitely.
2. iButtons=4'b0100 held, iEventReady=1 -> exactly one oPressPulse=4'b0100 within 2+4+1+8+1 cycles. oState=4'b0100, oEventCode=3'b110 valid for 1 cycle.
3. Bounce on ch1: toggle every 3 cycles for 30 cycles, then hold 1 -> no pulse/event during bounce (SETTLE aborts). Exactly one press {1,01} after 8 stable cycles.
4. Backpressure: iEventReady=0; press ch0 then ch3 -> event {1,00} valid and stable, ch3 oState stays 0, oBusy=1. Pulse iEventReady for 1 cycle -> event accepted. Later {1,11} is reported and ch3 is committed.
5. Release: ch2 from 1 to 0 held -> oReleasePulse=4'b0100 for 1 cycle, event {0,10}, oState[2]=0.
6. Assert reset during SETTLE of ch0 (input held 1) -> outputs 0 at once, no pulse. After release ch0 is re-debounced from scratch; press pulse occurs no earlier than 2+1+8+1 cycles after release.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the time-multiplexed button debouncer: FSM encoding,
// event-code field layout and elaboration-time helpers.
package debounce_pkg;

   localparam logic [1:0] ST_SCAN   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;
   localparam logic [1:0] ST_REPORT = 2'd3;

   localparam logic EDGE_PRESS   = 1'b1;
   localparam logic EDGE_RELEASE = 1'b0;

   // Event code layout: channel index from bit EV_IDX_LSB, edge flag just above it.
   localparam int EV_IDX_LSB = 0;

   function automatic int clog2Int(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   function automatic int atLeastOne(input int value);
      return (value < 1) ? 1 : value;
   endfunction

   function automatic int evEdgeBit(input int idxW);
      return EV_IDX_LSB + idxW;
   endfunction

endpackage

// File: rtl/input_sync.sv
// N-bit two-flop synchronizer for asynchronous button pins.
module input_sync #(
   parameter int WIDTH = 1
) (
   input  logic             iClock,
   input  logic             iReset_n,
   input  logic [WIDTH-1:0] iAsync,
   output logic [WIDTH-1:0] oSync
);

   logic [WIDTH-1:0] stage1;

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         stage1 <= '0;
         oSync  <= '0;
      end else begin
         // NOTE: non-blocking so each stage captures the pre-edge value; blocking would merge the two flops into one.
         stage1 <= iAsync;
         oSync  <= stage1;
      end
   end

endmodule

// File: rtl/debounce_scheduler.sv
// Debounces N buttons with one settle counter shared round-robin by a small FSM,
// producing levels, one-cycle edge pulses and a valid/ready event record.
module debounce_scheduler
   import debounce_pkg::*;
#(
   parameter  int N_BTN         = 4,
   parameter  int SETTLE_CYCLES = 524288,
   localparam int IDX_W         = atLeastOne(clog2Int(N_BTN))
) (
   input  logic             iClock,
   input  logic             iReset_n,
   input  logic [N_BTN-1:0] iButtons,
   input  logic             iEventReady,
   output logic [N_BTN-1:0] oState,
   output logic [N_BTN-1:0] oPressPulse,
   output logic [N_BTN-1:0] oReleasePulse,
   output logic             oEventValid,
   output logic [IDX_W:0]   oEventCode,
   output logic             oBusy,
   output logic [IDX_W-1:0] oChannel
);

   localparam int CNT_W = atLeastOne(clog2Int(SETTLE_CYCLES));
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(N_BTN - 1);

   logic [N_BTN-1:0] syncButtons;
   logic [1:0]       state;
   logic [IDX_W-1:0] scanPtr;
   logic [IDX_W-1:0] nextPtr;
   logic [CNT_W-1:0] settleCnt;
   logic             target;
   logic             sample;

   input_sync #(.WIDTH(N_BTN)) uSync (
      .iClock   (iClock),
      .iReset_n (iReset_n),
      .iAsync   (iButtons),
      .oSync    (syncButtons)
   );

   assign sample   = syncButtons[scanPtr];
   assign nextPtr  = (scanPtr == PTR_LAST) ? '0 : scanPtr + 1'b1;
   assign oBusy    = (state != ST_SCAN);
   assign oChannel = scanPtr;

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         state         <= ST_SCAN;
         scanPtr       <= '0;
         settleCnt     <= '0;
         target        <= 1'b0;
         oState        <= '0;
         oPressPulse   <= '0;
         oReleasePulse <= '0;
         oEventValid   <= 1'b0;
         oEventCode    <= '0;
      end else begin
         // Pulses are set only by COMMIT, so they are high for exactly the first REPORT cycle.
         oPressPulse   <= '0;
         oReleasePulse <= '0;
         case (state)
            ST_SCAN: begin
               if (sample != oState[scanPtr]) begin
                  target    <= sample;
                  settleCnt <= '0;
                  state     <= ST_SETTLE;
               end else begin
                  scanPtr <= nextPtr;
               end
            end
            ST_SETTLE: begin
               if (sample != target) begin
                  state   <= ST_SCAN;
                  scanPtr <= nextPtr;
               end else if (settleCnt == CNT_LAST) begin
                  state <= ST_COMMIT;
               end else begin
                  settleCnt <= settleCnt + 1'b1;
               end
            end
            ST_COMMIT: begin
               oState[scanPtr]                   <= target;
               oPressPulse[scanPtr]              <= (target == EDGE_PRESS);
               oReleasePulse[scanPtr]            <= (target == EDGE_RELEASE);
               oEventCode[evEdgeBit(IDX_W)]      <= target;
               oEventCode[EV_IDX_LSB +: IDX_W]   <= scanPtr;
               oEventValid                       <= 1'b1;
               state                             <= ST_REPORT;
            end
            ST_REPORT: begin
               // Scanning stays parked here; other channels are re-examined as levels afterwards.
               if (oEventValid && iEventReady) begin
                  oEventValid <= 1'b0;
                  scanPtr     <= nextPtr;
                  state       <= ST_SCAN;
               end
            end
            default: state <= ST_SCAN;
         endcase
      end
   end

endmodule
